// File: rtl/arith_fifo_stage.sv
// Chainable arithmetic stage: DEPTH-entry {op, data} FIFO feeding an iterative
// shift-add multiplier / restoring divider that retires one result per H+3 cycles.
module arith_fifo_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             write_req,
    input  logic             write_op,
    input  logic [WIDTH-1:0] fifo_write_data,
    output logic             full_out,
    input  logic             full_in,
    output logic             done_sig,
    output logic [WIDTH-1:0] result,
    output logic             div0,
    output logic             busy
);

    localparam int H  = WIDTH / 2;
    localparam int CW = $clog2(H) + 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH:0]   mem [DEPTH];
    logic [WIDTH:0]   rd_data;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             wr_en, pop;

    logic             op_q;
    logic [H-1:0]     b_q;
    logic [WIDTH-1:0] mcand;
    logic [H-1:0]     mplier;
    logic [WIDTH-1:0] acc;
    logic [H-1:0]     quo;
    logic [H-1:0]     rem;
    logic [CW-1:0]    cnt;

    // One restoring-division step; returns {remainder, quotient}. With d==0 every
    // step subtracts nothing, so quotient fills with ones and remainder becomes A.
    function automatic logic [WIDTH-1:0] div_step(input logic [H-1:0] r,
                                                   input logic [H-1:0] q,
                                                   input logic [H-1:0] d);
        logic [H:0] t;
        logic       ge;
        t  = {r, q[H-1]};
        ge = (t >= {1'b0, d});
        if (ge)
            t = t - {1'b0, d};
        return {t[H-1:0], q[H-2:0], ge};
    endfunction

    assign full_out = (count == FULL_CNT);
    assign wr_en    = write_req && !full_out;
    assign busy     = (state != IDLE) || (count != '0);

    // FIFO control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {write_op, fifo_write_data};
        if (pop)
            rd_data <= mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: if (count != '0) begin
                pop       = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: state_nxt = CALC;
            CALC: if (cnt == CW'(H-1)) state_nxt = DONE;
            DONE: if (!full_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (state == LOAD)
            cnt <= '0;
        else if (state == CALC)
            cnt <= cnt + 1'b1;
    end

    // Engine datapath: both algorithms step together, op selects at retirement
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            op_q   <= rd_data[WIDTH];
            b_q    <= rd_data[H-1:0];
            mcand  <= {{H{1'b0}}, rd_data[WIDTH-1:H]};
            mplier <= rd_data[H-1:0];
            acc    <= '0;
            quo    <= rd_data[WIDTH-1:H];
            rem    <= '0;
        end else if (state == CALC) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand      <= mcand << 1;
            mplier     <= mplier >> 1;
            {rem, quo} <= div_step(rem, quo, b_q);
        end
    end

    // Output register: done pulse and held result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_sig <= 1'b0;
            result   <= '0;
            div0     <= 1'b0;
        end else begin
            done_sig <= 1'b0;
            if (state == DONE && !full_in) begin
                done_sig <= 1'b1;
                result   <= op_q ? {quo, rem} : acc;
                div0     <= op_q && (b_q == '0);
            end
        end
    end

endmodule

// File: doc/arith_fifo_stage.md
Name: arith_fifo_stage

Overview:
- Parametrised, chainable arithmetic stage: a DEPTH-entry input FIFO feeds an iterative engine that runs multiply or divide, selected per word.
- Input word packs two operands; output handshake is done_sig gated by the downstream full_in.
- Successor to the fixed 16-bit divider/multiplier interface pair: one block instantiated N times in a chain, each stage's done_sig/result driving the next stage's write_req/fifo_write_data.

Parameters:
- WIDTH, 16, data/result width; even, >=4; H = WIDTH/2 is the operand width.
- DEPTH, 8, FIFO entries; power of two, >=2.
- AW, 3, FIFO pointer width = log2(DEPTH).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- write_req  in  1  write strobe; accepted when full_out=0.
- write_op  in  1  op for this word: 0 multiply, 1 divide; stored in FIFO alongside data.
- fifo_write_data  in  WIDTH  A=[WIDTH-1:H], B=[H-1:0].
- full_out  out  1  FIFO full (count==DEPTH).
- full_in  in  1  downstream full; blocks done_sig.
- done_sig  out  1  one-cycle pulse: result valid.
- result  out  WIDTH  multiply: A*B; divide: {quotient, remainder}.
- div0  out  1  valid with done_sig: divide with B==0.
- busy  out  1  engine not IDLE or FIFO non-empty.

Behaviour:
- Reset (async, rst_n=0): FIFO pointers/count=0, FSM=IDLE; full_out=0, done_sig=0, result=0, div0=0, busy=0. Reset mid-operation discards the FIFO contents and any in-flight calculation; there is no output after release.
- FIFO storage is WIDTH+1 bits ({op, data}).
  - Write occurs when write_req && !full_out. A write while full is dropped silently, with no state change.
  - Pop occurs only in IDLE with count!=0. Registered read: data is available in LOAD.
  - Same-cycle write+pop: count unchanged, both take effect.
  - full_out is derived from the registered count, so a write in the same cycle as a pop from a full FIFO is still rejected.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE -> LOAD when count!=0 (issues pop).
  - LOAD: latch A, B, op; clear accumulator and iteration counter -> CALC.
  - CALC: exactly H cycles.
    - Multiply: shift-add, LSB first; product is 2H bits, exact.
    - Divide: restoring division, one quotient bit per cycle, MSB first.
    - After H cycles -> DONE.
  - DONE: if full_in=0, assert done_sig for one cycle, drive result/div0 -> IDLE. If full_in=1, stay in DONE with done_sig=0 and result held stable until full_in=0.
- Divide by zero: quotient = all ones (H bits), remainder = A, div0=1. The engine still spends H CALC cycles.
- result and div0 are registered. They hold their last value after done_sig until the next done_sig.
- Latency, with FIFO empty and full_in=0: write accepted at edge 0 -> done_sig high in the cycle after edge H+3 (WIDTH=16: edge 11).
- Throughput: one result per H+3 cycles. The next pop occurs in the IDLE cycle following DONE.
- Results appear in write order; there is no reordering.
- busy=0 only when FSM is IDLE and count==0.

Test Plan:
- WIDTH=16, DEPTH=8, full_in=0; write op=0, data 0x0C0D -> single done_sig at edge 11, result=0x009C, div0=0.
- Write op=1, data 0x6407 (100/7) -> result=0x0E02, div0=0. Then write op=1, data 0xFF10 (255/16) -> result=0x0F0F.
- Divide by zero: op=1, data 0x2A00 -> result=0xFF2A, div0=1, asserted exactly with done_sig. Next op=0, data 0x0303 -> result=0x0009, div0=0.
- Backpressure: full_in=1, 12 back-to-back writes of 0x0101..0x010C, op=0.
  - Exactly 9 accepted (8 in FIFO + 1 in engine); full_out=1 from the edge after the 9th write; writes 10-12 dropped.
  - Release full_in -> 9 done_sig pulses, results 0x0001..0x0009 in order. busy then falls to 0.
- Stall hold: during DONE, toggle full_in 1,1,0 -> result stable throughout; done_sig only in the cycle where full_in=0, width one cycle.
- Reset mid-CALC: 3 words queued, assert rst_n=0 for 1 cycle during the first calculation -> outputs/count return to 0 immediately; no done_sig after release. A fresh write behaves as in the first scenario.
